calendar_counter: RTL

- Upstream stage of the day-of-week converter. Keeps the current Gregorian date as registered date/month/year fields and advances it by one day per day_tick.
- Accepts a validated software/user date load through a valid/ready handshake.
- Output field widths match the converter inputs (date 5b, month 4b, year 12b), so the outputs wire straight in.
- Emits a one-cycle `changed` strobe whenever the date updates, so downstream logic can sample the converted weekday.

---
 rtl/cal_pkg.sv | 40 ++++
 rtl/month_length.sv | 27 ++
 rtl/calendar_counter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/cal_pkg.sv
// Shared definitions for the calendar counter.
//   state_t    : controller states (RUN accepts loads/ticks, VALIDATE checks a staged load)
//   JAN..DEC   : month encodings (1-based, matching the converter inputs)
//   BASE_DAYS  : days per month for a non-leap year, indexed by month-1
//   is_leap    : Gregorian leap-year test on a 12-bit year
package cal_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        VALIDATE = 1'b1
    } state_t;

    localparam logic [3:0] JAN = 4'd1;
    localparam logic [3:0] FEB = 4'd2;
    localparam logic [3:0] MAR = 4'd3;
    localparam logic [3:0] APR = 4'd4;
    localparam logic [3:0] MAY = 4'd5;
    localparam logic [3:0] JUN = 4'd6;
    localparam logic [3:0] JUL = 4'd7;
    localparam logic [3:0] AUG = 4'd8;
    localparam logic [3:0] SEP = 4'd9;
    localparam logic [3:0] OCT = 4'd10;
    localparam logic [3:0] NOV = 4'd11;
    localparam logic [3:0] DEC = 4'd12;

    localparam logic [4:0] BASE_DAYS [12] = '{
        5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
        5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
    };

    // Divisible by 4, and not a century year unless divisible by 400.
    function automatic logic is_leap(input logic [11:0] year);
        logic div100;
        logic div400;
        div100 = ((year % 12'd100) == 12'd0);
        div400 = ((year % 12'd400) == 12'd0);
        return (year[1:0] == 2'b00) && (!div100 || div400);
    endfunction

endpackage

// File: rtl/month_length.sv
// Combinational days-in-month lookup.
//   i_month : month 1-12 (anything else is illegal)
//   i_year  : year, only used for the February leap adjustment
//   o_days  : number of days in the month, 0 for an illegal month
module month_length
    import cal_pkg::*;
(
    input  logic [3:0]  i_month,
    input  logic [11:0] i_year,
    output logic [4:0]  o_days
);

    logic [3:0] w_idx;

    assign w_idx = i_month - 4'd1;

    always_comb begin
        o_days = 5'd0;
        if ((i_month >= JAN) && (i_month <= DEC)) begin
            o_days = BASE_DAYS[w_idx];
            if ((i_month == FEB) && is_leap(i_year)) begin
                o_days = 5'd29;
            end
        end
    end

endmodule

// File: rtl/calendar_counter.sv
// Gregorian date register feeding the day-of-week converter.
// Advances one day per i_day_tick and accepts a checked date load over a
// valid/ready handshake. A load takes two cycles (stage, then validate);
// ticks arriving meanwhile are banked in a saturating 2-bit counter and
// replayed one per cycle once back in RUN.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_day_tick          : one-cycle pulse, advance by one day
//   i_load_valid        : load request, o_load_ready high in RUN
//   i_load_date/month/year : requested date
//   o_date/month/year   : current date (5b/4b/12b)
//   o_changed           : pulse, date fields updated
//   o_load_ok/o_load_err: pulse, load applied / rejected
//   o_wrap              : pulse, rolled from 31 Dec MAX_YEAR to 1 Jan MIN_YEAR
module calendar_counter
    import cal_pkg::*;
#(
    parameter int MIN_YEAR  = 1700,
    parameter int MAX_YEAR  = 2399,
    parameter int RST_DATE  = 1,
    parameter int RST_MONTH = 1,
    parameter int RST_YEAR  = 2000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_day_tick,
    input  logic        i_load_valid,
    output logic        o_load_ready,
    input  logic [4:0]  i_load_date,
    input  logic [3:0]  i_load_month,
    input  logic [11:0] i_load_year,
    output logic [4:0]  o_date,
    output logic [3:0]  o_month,
    output logic [11:0] o_year,
    output logic        o_changed,
    output logic        o_load_ok,
    output logic        o_load_err,
    output logic        o_wrap
);

    localparam logic [11:0] MIN_Y = 12'(MIN_YEAR);
    localparam logic [11:0] MAX_Y = 12'(MAX_YEAR);
    localparam logic [4:0]  RST_D = 5'(RST_DATE);
    localparam logic [3:0]  RST_M = 4'(RST_MONTH);
    localparam logic [11:0] RST_Y = 12'(RST_YEAR);

    state_t      r_state;
    logic        r_load_ready;
    logic [4:0]  r_date;
    logic [3:0]  r_month;
    logic [11:0] r_year;
    logic [4:0]  r_stg_date;
    logic [3:0]  r_stg_month;
    logic [11:0] r_stg_year;
    logic [1:0]  r_pending;
    logic        r_changed;
    logic        r_load_ok;
    logic        r_load_err;
    logic        r_wrap;

    logic [4:0]  w_cur_days;
    logic [4:0]  w_stg_days;
    logic [4:0]  w_nxt_date;
    logic [3:0]  w_nxt_month;
    logic [11:0] w_nxt_year;
    logic        w_nxt_wrap;
    logic        w_stg_ok;
    logic [1:0]  w_pend_inc;
    logic        w_have_pend;

    month_length u_len_cur (
        .i_month (r_month),
        .i_year  (r_year),
        .o_days  (w_cur_days)
    );

    month_length u_len_stg (
        .i_month (r_stg_month),
        .i_year  (r_stg_year),
        .o_days  (w_stg_days)
    );

    // Next-day computation from the current registers.
    always_comb begin
        w_nxt_date  = r_date + 5'd1;
        w_nxt_month = r_month;
        w_nxt_year  = r_year;
        w_nxt_wrap  = 1'b0;
        if (r_date >= w_cur_days) begin
            w_nxt_date = 5'd1;
            if (r_month >= DEC) begin
                w_nxt_month = JAN;
                if (r_year >= MAX_Y) begin
                    w_nxt_year = MIN_Y;
                    w_nxt_wrap = 1'b1;
                end else begin
                    w_nxt_year = r_year + 12'd1;
                end
            end else begin
                w_nxt_month = r_month + 4'd1;
            end
        end
    end

    // An illegal month yields w_stg_days == 0, which also fails the date test.
    assign w_stg_ok = (w_stg_days != 5'd0) &&
                      (r_stg_date != 5'd0) &&
                      (r_stg_date <= w_stg_days) &&
                      (r_stg_year >= MIN_Y) &&
                      (r_stg_year <= MAX_Y);

    assign w_pend_inc  = (r_pending == 2'd3) ? 2'd3 : (r_pending + 2'd1);
    assign w_have_pend = (r_pending != 2'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= RUN;
            r_load_ready <= 1'b1;
            r_date       <= RST_D;
            r_month      <= RST_M;
            r_year       <= RST_Y;
            r_stg_date   <= 5'd0;
            r_stg_month  <= 4'd0;
            r_stg_year   <= 12'd0;
            r_pending    <= 2'd0;
            r_changed    <= 1'b0;
            r_load_ok    <= 1'b0;
            r_load_err   <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            r_changed  <= 1'b0;
            r_load_ok  <= 1'b0;
            r_load_err <= 1'b0;
            r_wrap     <= 1'b0;
            case (r_state)
                RUN: begin
                    if (i_load_valid) begin
                        // Load wins the cycle: no day is applied, a tick is banked.
                        r_stg_date   <= i_load_date;
                        r_stg_month  <= i_load_month;
                        r_stg_year   <= i_load_year;
                        r_state      <= VALIDATE;
                        r_load_ready <= 1'b0;
                        if (i_day_tick) begin
                            r_pending <= w_pend_inc;
                        end
                    end else if (w_have_pend || i_day_tick) begin
                        r_date    <= w_nxt_date;
                        r_month   <= w_nxt_month;
                        r_year    <= w_nxt_year;
                        r_changed <= 1'b1;
                        r_wrap    <= w_nxt_wrap;
                        // Pending consumed first; a fresh tick replaces it (net 0).
                        if (w_have_pend && !i_day_tick) begin
                            r_pending <= r_pending - 2'd1;
                        end
                    end
                end
                VALIDATE: begin
                    r_state      <= RUN;
                    r_load_ready <= 1'b1;
                    if (i_day_tick) begin
                        r_pending <= w_pend_inc;
                    end
                    if (w_stg_ok) begin
                        r_date    <= r_stg_date;
                        r_month   <= r_stg_month;
                        r_year    <= r_stg_year;
                        r_load_ok <= 1'b1;
                        r_changed <= 1'b1;
                    end else begin
                        r_load_err <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= RUN;
                    r_load_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_load_ready = r_load_ready;
    assign o_date       = r_date;
    assign o_month      = r_month;
    assign o_year       = r_year;
    assign o_changed    = r_changed;
    assign o_load_ok    = r_load_ok;
    assign o_load_err   = r_load_err;
    assign o_wrap       = r_wrap;

endmodule
